// File: rtl/uart_rx_bit_timer.sv
`default_nettype none
// ==========================================================================
// Module : uart_rx_bit_timer
// Desc   : UART RX oversampling bit timer with 3-sample mid-bit majority vote
// Rev    : 1.0
// ==========================================================================
module uart_rx_bit_timer #(
  parameter int PRESCALE_W = 6,
  parameter int BIT_CNT_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic [BIT_CNT_W-1:0]  frame_bits,
  input  logic                  rx_in,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BIT_CNT_W-1:0]  bit_count,
  output logic                  busy,
  output logic                  bit_done,
  output logic                  frame_done,
  output logic                  sample_valid,
  output logic                  sampled_bit,
  output logic                  cfg_error
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [PRESCALE_W-1:0] P_ONE = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] P_MIN = PRESCALE_W'(4);
  localparam logic [BIT_CNT_W-1:0]  F_ONE = BIT_CNT_W'(1);

  state_t                state_q, state_d;
  logic [PRESCALE_W-1:0] edge_q, edge_d;
  logic [PRESCALE_W-1:0] p_q, p_d;
  logic [BIT_CNT_W-1:0]  bit_q, bit_d;
  logic [BIT_CNT_W-1:0]  f_q, f_d;
  logic [2:0]            samp_q, samp_d;
  logic                  sampled_bit_q, sampled_bit_d;
  logic                  sample_valid_q, sample_valid_d;
  logic                  cfg_error_q, cfg_error_d;

  logic [PRESCALE_W-1:0] mid;
  logic                  cfg_ok;
  logic                  in_run;
  logic                  last_edge;
  logic                  last_bit;
  logic                  at_mid_hi;
  logic                  do_sample;

  always_comb begin
    mid       = p_q >> 1;
    cfg_ok    = (prescale >= P_MIN) && (frame_bits != '0);
    in_run    = (state_q == RUN);
    last_edge = in_run && (edge_q == p_q - P_ONE);
    last_bit  = (bit_q == f_q - F_ONE);
    at_mid_hi = in_run && (edge_q == mid + P_ONE);
    do_sample = in_run && ((edge_q == mid - P_ONE) || (edge_q == mid) || at_mid_hi);
  end

  always_comb begin
    state_d        = state_q;
    edge_d         = edge_q;
    bit_d          = bit_q;
    p_d            = p_q;
    f_d            = f_q;
    samp_d         = samp_q;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    cfg_error_d    = 1'b0;

    // Sampling runs off registered state only, so a vote already in flight
    // still completes even if enable drops on the third sample edge.
    if (do_sample) begin
      samp_d = {samp_q[1:0], rx_in};
    end
    if (at_mid_hi) begin
      sample_valid_d = 1'b1;
      sampled_bit_d  = (samp_q[1] & samp_q[0]) | (samp_q[1] & rx_in) | (samp_q[0] & rx_in);
    end

    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        if (enable) begin
          if (cfg_ok) begin
            p_d     = prescale;
            f_d     = frame_bits;
            state_d = RUN;
          end else begin
            cfg_error_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end else if (last_edge) begin
          edge_d = '0;
          bit_d  = bit_q + F_ONE;
          if (last_bit) begin
            state_d = HOLD;
          end
        end else begin
          edge_d = edge_q + P_ONE;
        end
      end
      HOLD: begin
        if (!enable) begin
          state_d = IDLE;
          edge_d  = '0;
          bit_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      edge_q         <= '0;
      bit_q          <= '0;
      p_q            <= '0;
      f_q            <= '0;
      samp_q         <= '0;
      sampled_bit_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      cfg_error_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      edge_q         <= edge_d;
      bit_q          <= bit_d;
      p_q            <= p_d;
      f_q            <= f_d;
      samp_q         <= samp_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      cfg_error_q    <= cfg_error_d;
    end
  end

  assign edge_count   = edge_q;
  assign bit_count    = bit_q;
  assign busy         = (state_q != IDLE);
  assign bit_done     = last_edge;
  assign frame_done   = last_edge && last_bit;
  assign sample_valid = sample_valid_q;
  assign sampled_bit  = sampled_bit_q;
  assign cfg_error    = cfg_error_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_bit_timer.sv
`default_nettype none
// ==========================================================================
// Module : tb_uart_rx_bit_timer
// Desc   : scoreboard bench for uart_rx_bit_timer strobes and counters
// Rev    : 1.0
// ==========================================================================
module tb_uart_rx_bit_timer;

  localparam int PW = 6;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic [PW-1:0] prescale;
  logic [BW-1:0] frame_bits;
  logic          rx_in;
  logic [PW-1:0] edge_count;
  logic [BW-1:0] bit_count;
  logic          busy;
  logic          bit_done;
  logic          frame_done;
  logic          sample_valid;
  logic          sampled_bit;
  logic          cfg_error;

  int n_checks = 0;
  int n_pass   = 0;
  int bd_q[$];
  int sv_q[$];

  uart_rx_bit_timer #(.PRESCALE_W(PW), .BIT_CNT_W(BW)) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .prescale     (prescale),
    .frame_bits   (frame_bits),
    .rx_in        (rx_in),
    .edge_count   (edge_count),
    .bit_count    (bit_count),
    .busy         (busy),
    .bit_done     (bit_done),
    .frame_done   (frame_done),
    .sample_valid (sample_valid),
    .sampled_bit  (sampled_bit),
    .cfg_error    (cfg_error)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic int maj3(input logic [2:0] v);
    return int'((v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]));
  endfunction

  // Strobe monitor: every strobe pops its expected record (sampled_bit/frame_done, bit_count, edge_count).
  always @(posedge clk) begin
    #1;
    if (bit_done === 1'b1) begin
      if (bd_q.size() == 0) check_eq("bit_done_unexpected", int'(bit_done), 0);
      else check_eq("bit_done", int'(frame_done) * 65536 + int'(bit_count) * 256 + int'(edge_count),
                    bd_q.pop_front());
    end else if (frame_done === 1'b1) begin
      check_eq("frame_done_without_bit_done", int'(frame_done), 0);
    end
    if (sample_valid === 1'b1) begin
      if (sv_q.size() == 0) check_eq("sample_valid_unexpected", int'(sample_valid), 0);
      else check_eq("sample", int'(sampled_bit) * 65536 + int'(bit_count) * 256 + int'(edge_count),
                    sv_q.pop_front());
    end
  end

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, int'(busy), 0);
    check_eq({tag, "_edge"}, int'(edge_count), 0);
    check_eq({tag, "_bits"}, int'(bit_count), 0);
  endtask

  // Runs one frame; chg_k rewrites prescale mid-frame, abort_k drops enable at that RUN cycle.
  task automatic run_frame(input int p, input int f, input logic [2:0] pe, input logic [2:0] po,
                           input int chg_k, input int abort_k);
    int mid;
    int e;
    int b;
    int ec;
    int bc;
    logic [2:0] pat;
    logic aborted;
    mid = p / 2;
    aborted = 1'b0;
    @(negedge clk);
    prescale   = PW'(p);
    frame_bits = BW'(f);
    enable     = 1'b1;
    rx_in      = 1'b1;
    for (int bi = 0; bi < f; bi++) begin
      pat = (bi % 2 == 1) ? po : pe;
      if (abort_k == 0 || bi * p + mid + 2 <= abort_k) begin
        ec = (mid + 2 == p) ? 0 : mid + 2;
        bc = (mid + 2 == p) ? bi + 1 : bi;
        sv_q.push_back(maj3(pat) * 65536 + bc * 256 + ec);
      end
      if (abort_k == 0 || (bi + 1) * p <= abort_k)
        bd_q.push_back(((bi == f - 1) ? 65536 : 0) + bi * 256 + (p - 1));
    end
    for (int k = 1; k <= f * p; k++) begin
      @(negedge clk);
      e = (k - 1) % p;
      b = (k - 1) / p;
      check_eq("run_edge", int'(edge_count), e);
      check_eq("run_bits", int'(bit_count), b);
      check_eq("run_busy", int'(busy), 1);
      pat = (b % 2 == 1) ? po : pe;
      rx_in = (e == mid - 1) ? pat[2] : (e == mid) ? pat[1] : (e == mid + 1) ? pat[0] : 1'b1;
      if (k == chg_k) prescale = PW'(8);
      if (k == abort_k) begin
        enable  = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    if (aborted) begin
      @(negedge clk);
      check_idle("abort");
      repeat (3) @(negedge clk);
    end else begin
      repeat (4) begin
        @(negedge clk);
        check_eq("hold_busy", int'(busy), 1);
        check_eq("hold_edge", int'(edge_count), 0);
        check_eq("hold_bits", int'(bit_count), f);
      end
      enable = 1'b0;
      @(negedge clk);
      check_idle("hold_exit");
    end
    check_eq("bd_queue_drained", bd_q.size(), 0);
    check_eq("sv_queue_drained", sv_q.size(), 0);
    bd_q.delete();
    sv_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no summary expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset      = 1'b1;
    enable     = 1'b0;
    prescale   = PW'(16);
    frame_bits = BW'(10);
    rx_in      = 1'b1;
    repeat (3) @(negedge clk);
    check_idle("reset");
    check_eq("reset_sample_valid", int'(sample_valid), 0);
    check_eq("reset_sampled_bit", int'(sampled_bit), 0);
    check_eq("reset_cfg_error", int'(cfg_error), 0);
    reset = 1'b0;

    run_frame(16, 10, 3'b111, 3'b111, 0, 0);

    // Reset mid-RUN on the third sample edge: the pending vote must be squashed.
    @(negedge clk);
    prescale = PW'(16); frame_bits = BW'(10); enable = 1'b1; rx_in = 1'b1;
    repeat (10) @(negedge clk);
    check_eq("pre_reset_edge", int'(edge_count), 9);
    check_eq("pre_reset_sampled_bit", int'(sampled_bit), 1);
    reset = 1'b1;
    @(negedge clk);
    check_idle("mid_reset");
    check_eq("mid_reset_sample_valid", int'(sample_valid), 0);
    check_eq("mid_reset_sampled_bit", int'(sampled_bit), 0);
    check_eq("mid_reset_bit_done", int'(bit_done), 0);
    reset = 1'b0; enable = 1'b0;
    @(negedge clk);

    run_frame(8, 1, 3'b011, 3'b011, 0, 0);
    run_frame(8, 1, 3'b001, 3'b001, 0, 0);
    run_frame(4, 3, 3'b110, 3'b100, 0, 0);
    run_frame(5, 2, 3'b010, 3'b101, 0, 0);

    // Illegal configurations keep the timer idle and flag cfg_error.
    @(negedge clk);
    prescale = PW'(3); frame_bits = BW'(10); enable = 1'b1;
    @(negedge clk);
    check_eq("cfg_p3_busy", int'(busy), 0);
    check_eq("cfg_p3_error", int'(cfg_error), 1);
    prescale = PW'(16); frame_bits = BW'(0);
    @(negedge clk);
    check_eq("cfg_f0_busy", int'(busy), 0);
    check_eq("cfg_f0_error", int'(cfg_error), 1);
    frame_bits = BW'(10);
    @(negedge clk);
    check_eq("cfg_fixed_error", int'(cfg_error), 0);
    check_eq("cfg_fixed_busy", int'(busy), 1);
    check_eq("cfg_fixed_edge", int'(edge_count), 0);
    enable = 1'b0;
    @(negedge clk);
    check_idle("cfg_exit");

    run_frame(16, 10, 3'b111, 3'b000, 0, 2 * 16 + 6);
    run_frame(16, 4, 3'b101, 3'b001, 20, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
